// File: rtl/toast_imem_prefetch_if.sv
// Fetch-side bundle for the instruction prefetch buffer: the request/grant/
// response memory bus, the redirect input and the valid/ready IF port.
interface toast_imem_prefetch_if #(
    parameter int unsigned REG_DATA_WIDTH  = 32,
    parameter int unsigned IMEM_ADDR_WIDTH = 32
);
    logic                       mem_req_o;
    logic [IMEM_ADDR_WIDTH-1:0] mem_addr_o;
    logic                       mem_gnt_i;
    logic                       mem_rvalid_i;
    logic [REG_DATA_WIDTH-1:0]  mem_rdata_i;
    logic                       redirect_i;
    logic [REG_DATA_WIDTH-1:0]  redirect_pc_i;
    logic [REG_DATA_WIDTH-1:0]  instr_o;
    logic [REG_DATA_WIDTH-1:0]  pc_o;
    logic                       valid_o;
    logic                       ready_i;

    // Prefetch buffer side
    modport master (
        output mem_req_o, mem_addr_o, instr_o, pc_o, valid_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, redirect_i, redirect_pc_i, ready_i
    );

    // Memory / pipeline side
    modport slave (
        input  mem_req_o, mem_addr_o, instr_o, pc_o, valid_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, redirect_i, redirect_pc_i, ready_i
    );
endinterface

// File: rtl/toast_imem_prefetch.sv
// Instruction prefetch buffer: sequential word fetches into an in-order FIFO
// of {instr, pc}, flushed on redirect with stale in-flight responses dropped.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_BOOT  | first cycle after reset, launches the fetch at BOOT_ADDR
// ST_FETCH | issuing sequential requests while credit is available
// ST_FULL  | outstanding + buffered == DEPTH, waiting for a pop
// ST_FLUSH | draining responses that belong to the pre-redirect stream
module toast_imem_prefetch #(
    parameter int unsigned                REG_DATA_WIDTH  = 32,
    parameter int unsigned                IMEM_ADDR_WIDTH = 32,
    parameter int unsigned                DEPTH           = 4,
    parameter logic [IMEM_ADDR_WIDTH-1:0] BOOT_ADDR       = '0
) (
    input  logic                 clk_i,
    input  logic                 resetn_i,
    toast_imem_prefetch_if.master bus
);
    localparam int unsigned   CW      = $clog2(DEPTH) + 1;
    localparam int unsigned   PW      = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {ST_BOOT, ST_FETCH, ST_FULL, ST_FLUSH} state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic                       r_req;
    logic [IMEM_ADDR_WIDTH-1:0] r_addr;
    logic [IMEM_ADDR_WIDTH-1:0] r_fetch_pc;
    logic [REG_DATA_WIDTH-1:0]  r_resp_pc;
    logic [CW-1:0]              r_out;
    logic [CW-1:0]              r_cnt;
    logic [CW-1:0]              r_stale;
    logic [PW-1:0]              r_rd_ptr;
    logic [PW-1:0]              r_wr_ptr;
    logic [REG_DATA_WIDTH-1:0]  r_fifo_instr [DEPTH];
    logic [REG_DATA_WIDTH-1:0]  r_fifo_pc    [DEPTH];

    logic                       w_gnt;
    logic                       w_redir;
    logic                       w_drop;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_pend_hold;
    logic                       w_room;
    logic                       w_issue;
    logic [CW-1:0]              w_out_nxt;
    logic [CW-1:0]              w_cnt_nxt;
    logic [CW-1:0]              w_stale_nxt;
    logic [REG_DATA_WIDTH-1:0]  w_redir_pc_r;
    logic [IMEM_ADDR_WIDTH-1:0] w_redir_pc;
    logic [IMEM_ADDR_WIDTH-1:0] w_pc_src;

    // Next-state, credit and stale accounting; the request is registered, so
    // this also decides what is presented on the bus next cycle.
    always_comb begin
        w_gnt        = r_req & bus.mem_gnt_i;
        w_pend_hold  = r_req & ~bus.mem_gnt_i;
        w_redir      = bus.redirect_i & (r_state != ST_BOOT);
        w_drop       = bus.mem_rvalid_i & (r_stale != '0);
        w_push       = bus.mem_rvalid_i & (r_stale == '0) & ~w_redir;
        w_pop        = (r_cnt != '0) & bus.ready_i;
        w_redir_pc_r = bus.redirect_pc_i & ~REG_DATA_WIDTH'(3);
        w_redir_pc   = IMEM_ADDR_WIDTH'(w_redir_pc_r);
        w_out_nxt    = r_out + CW'(w_gnt) - CW'(bus.mem_rvalid_i);
        w_cnt_nxt    = r_cnt + CW'(w_push) - CW'(w_pop);
        if (w_redir) begin
            w_cnt_nxt = '0;
        end
        // Every outstanding request counts against the buffer, stale or not,
        // so a late stale burst can never overrun the counters.
        w_room      = ({1'b0, w_out_nxt} + {1'b0, w_cnt_nxt}) < {1'b0, DEPTH_C};
        w_stale_nxt = r_stale - CW'(w_drop);
        if (w_redir) begin
            w_stale_nxt = w_out_nxt + CW'(w_pend_hold);
        end

        w_state_nxt = r_state;
        unique case (r_state)
            ST_BOOT:           w_state_nxt = ST_FETCH;
            ST_FETCH, ST_FULL: w_state_nxt = w_room ? ST_FETCH : ST_FULL;
            ST_FLUSH:          w_state_nxt = (w_stale_nxt == '0) ? ST_FETCH : ST_FLUSH;
            default:           w_state_nxt = ST_BOOT;
        endcase
        if (w_redir) begin
            w_state_nxt = (w_stale_nxt != '0) ? ST_FLUSH : ST_FETCH;
        end

        // An ungranted request is never withdrawn or changed.
        w_issue  = ~w_pend_hold & (w_state_nxt == ST_FETCH) & w_room;
        w_pc_src = w_redir ? w_redir_pc : r_fetch_pc;
    end

    // State register.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request, counters and FIFO storage.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_req      <= 1'b0;
            r_addr     <= BOOT_ADDR;
            r_fetch_pc <= BOOT_ADDR;
            r_resp_pc  <= REG_DATA_WIDTH'(BOOT_ADDR);
            r_out      <= '0;
            r_cnt      <= '0;
            r_stale    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_instr[i] <= '0;
                r_fifo_pc[i]    <= '0;
            end
        end else begin
            r_out   <= w_out_nxt;
            r_cnt   <= w_cnt_nxt;
            r_stale <= w_stale_nxt;
            r_req   <= w_pend_hold | w_issue;
            if (w_issue) begin
                r_addr     <= w_pc_src;
                r_fetch_pc <= w_pc_src + IMEM_ADDR_WIDTH'(4);
            end else if (w_redir) begin
                r_fetch_pc <= w_redir_pc;
            end
            if (w_redir) begin
                r_rd_ptr  <= '0;
                r_wr_ptr  <= '0;
                r_resp_pc <= w_redir_pc_r;
            end else begin
                if (w_push) begin
                    r_fifo_instr[r_wr_ptr] <= bus.mem_rdata_i;
                    r_fifo_pc[r_wr_ptr]    <= r_resp_pc;
                    r_wr_ptr               <= r_wr_ptr + PW'(1);
                    r_resp_pc              <= r_resp_pc + REG_DATA_WIDTH'(4);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
            end
        end
    end

    assign bus.mem_req_o  = r_req;
    assign bus.mem_addr_o = r_addr;
    assign bus.valid_o    = (r_cnt != '0);
    assign bus.instr_o    = r_fifo_instr[r_rd_ptr];
    assign bus.pc_o       = r_fifo_pc[r_rd_ptr];

    a_no_overflow: assert property (@(posedge clk_i) disable iff (!resetn_i)
        !(w_push && !w_pop && (r_cnt == DEPTH_C)));
endmodule

// File: tb/tb_toast_imem_prefetch.sv
// Directed bench for the prefetch buffer with a small in-order memory model.
module tb_toast_imem_prefetch;
    localparam logic [31:0] KEY = 32'h5A00_0000;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    logic rsp_en = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_grants = 0;
    logic [31:0] q[$];

    toast_imem_prefetch_if #(.REG_DATA_WIDTH(32), .IMEM_ADDR_WIDTH(32)) bus ();

    toast_imem_prefetch #(
        .REG_DATA_WIDTH(32), .IMEM_ADDR_WIDTH(32), .DEPTH(4), .BOOT_ADDR(32'h0)
    ) dut (
        .clk_i   (clk),
        .resetn_i(resetn),
        .bus     (bus)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        resetn             = 1'b0;
        rsp_en             = 1'b1;
        bus.mem_gnt_i      = 1'b1;
        bus.ready_i        = 1'b1;
        bus.redirect_i     = 1'b0;
        bus.redirect_pc_i  = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    // Memory: grant seen at the edge queues the address; responses in order,
    // earliest the cycle after grant, data = address ^ KEY.
    initial begin
        logic        granting;
        logic [31:0] g_addr;
        logic [31:0] g_tmp;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'h0;
        forever begin
            @(negedge clk);
            granting = resetn && bus.mem_req_o && bus.mem_gnt_i;
            g_addr   = bus.mem_addr_o;
            @(posedge clk);
            #1;
            if (!resetn) begin
                q.delete();
                bus.mem_rvalid_i = 1'b0;
                n_grants         = 0;
            end else begin
                if (bus.mem_rvalid_i && q.size() > 0) g_tmp = q.pop_front();
                if (granting) begin
                    q.push_back(g_addr);
                    n_grants++;
                end
                if (rsp_en && q.size() > 0) begin
                    bus.mem_rvalid_i = 1'b1;
                    bus.mem_rdata_i  = q[0] ^ KEY;
                end else begin
                    bus.mem_rvalid_i = 1'b0;
                end
            end
        end
    end

    initial begin
        // Streaming: reset values, then addresses 0,4,8.. and one word per cycle.
        do_reset();
        chk("rst_req",   bus.mem_req_o,  32'h0);
        chk("rst_addr",  bus.mem_addr_o, 32'h0);
        chk("rst_valid", bus.valid_o,    32'h0);
        chk("rst_instr", bus.instr_o,    32'h0);
        chk("rst_pc",    bus.pc_o,       32'h0);
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            chk("s1_addr", bus.mem_addr_o, 32'((k - 1) * 4));
            if (k >= 3) begin
                chk("s1_valid", bus.valid_o, 32'h1);
                chk("s1_pc",    bus.pc_o,    32'((k - 3) * 4));
                chk("s1_instr", bus.instr_o, 32'((k - 3) * 4) ^ KEY);
            end
        end

        // Stall: buffer fills with four words, requests stop, resume at 16.
        do_reset();
        bus.ready_i = 1'b0;
        tick(10);
        chk("s2_grants", 32'(n_grants), 32'd4);
        chk("s2_req",    bus.mem_req_o, 32'h0);
        chk("s2_valid",  bus.valid_o,   32'h1);
        chk("s2_pc0",    bus.pc_o,      32'h0);
        chk("s2_instr0", bus.instr_o,   KEY);
        bus.ready_i = 1'b1;
        tick(1);
        chk("s2_req_resume",  bus.mem_req_o,  32'h1);
        chk("s2_addr_resume", bus.mem_addr_o, 32'h10);
        chk("s2_pc4", bus.pc_o, 32'h4);
        tick(1);
        chk("s2_pc8", bus.pc_o, 32'h8);
        tick(1);
        chk("s2_pc12", bus.pc_o, 32'hC);
        tick(1);
        chk("s2_pc16", bus.pc_o, 32'h10);

        // Grant withheld three cycles: request held at 0x8.
        do_reset();
        tick(3);
        chk("s3_addr8", bus.mem_addr_o, 32'h8);
        bus.mem_gnt_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("s3_hold_req",  bus.mem_req_o,  32'h1);
            chk("s3_hold_addr", bus.mem_addr_o, 32'h8);
        end
        bus.mem_gnt_i = 1'b1;
        tick(1);
        chk("s3_addr_c", bus.mem_addr_o, 32'hC);
        tick(1);
        chk("s3_valid", bus.valid_o, 32'h1);
        chk("s3_pc8",   bus.pc_o,    32'h8);

        // Redirect with 0x10,0x14 in flight and 0x18 pending ungranted.
        do_reset();
        tick(5);
        chk("s4_addr10", bus.mem_addr_o, 32'h10);
        rsp_en = 1'b0;
        tick(2);
        chk("s4_addr18", bus.mem_addr_o, 32'h18);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h203;
        bus.mem_gnt_i     = 1'b0;
        tick(1);
        bus.redirect_i = 1'b0;
        chk("s4_valid_redir", bus.valid_o,    32'h0);
        chk("s4_hold_req",    bus.mem_req_o,  32'h1);
        chk("s4_hold_addr",   bus.mem_addr_o, 32'h18);
        tick(1);
        chk("s4_hold_addr2",  bus.mem_addr_o, 32'h18);
        bus.mem_gnt_i = 1'b1;
        tick(1);
        chk("s4_flush_req", bus.mem_req_o, 32'h0);
        rsp_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("s4_drop_valid", bus.valid_o,   32'h0);
            chk("s4_drop_req",   bus.mem_req_o, 32'h0);
        end
        tick(1);
        chk("s4_new_req",  bus.mem_req_o,  32'h1);
        chk("s4_new_addr", bus.mem_addr_o, 32'h200);
        tick(2);
        chk("s4_valid", bus.valid_o, 32'h1);
        chk("s4_pc",    bus.pc_o,    32'h200);
        chk("s4_instr", bus.instr_o, 32'h200 ^ KEY);

        // Redirect coinciding with a response and a pop.
        do_reset();
        tick(4);
        chk("s5_pre_pc", bus.pc_o, 32'h4);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'h40;
        tick(1);
        bus.redirect_i = 1'b0;
        chk("s5_valid", bus.valid_o,   32'h0);
        chk("s5_req",   bus.mem_req_o, 32'h0);
        tick(1);
        chk("s5_new_req",  bus.mem_req_o,  32'h1);
        chk("s5_new_addr", bus.mem_addr_o, 32'h40);
        chk("s5_valid2",   bus.valid_o,    32'h0);
        tick(2);
        chk("s5_pc",    bus.pc_o,    32'h40);
        chk("s5_instr", bus.instr_o, 32'h40 ^ KEY);

        // Address wrap from 0xFFFF_FFFC.
        do_reset();
        tick(1);
        bus.redirect_i    = 1'b1;
        bus.redirect_pc_i = 32'hFFFF_FFFC;
        tick(1);
        bus.redirect_i = 1'b0;
        chk("s6_flush_req", bus.mem_req_o, 32'h0);
        tick(1);
        chk("s6_addr_top", bus.mem_addr_o, 32'hFFFF_FFFC);
        tick(1);
        chk("s6_addr_wrap", bus.mem_addr_o, 32'h0);
        chk("s6_req_wrap",  bus.mem_req_o,  32'h1);
        tick(1);
        chk("s6_pc_top",    bus.pc_o,    32'hFFFF_FFFC);
        chk("s6_instr_top", bus.instr_o, 32'hFFFF_FFFC ^ KEY);
        tick(1);
        chk("s6_pc_wrap",    bus.pc_o,    32'h0);
        chk("s6_instr_wrap", bus.instr_o, KEY);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
